// File: rtl/staged_enable_sequencer.sv
// Power-up sequencer: raises per-stage enables in order with settle delays and
// ready handshakes, watches for timeout / ready loss, and drains in reverse on restart.
module staged_enable_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int DELAY       = 62,
  parameter int TIMEOUT     = 1000,
  parameter int DRAIN_DELAY = 8
) (
  input  logic                          clk40,
  input  logic                          rst,
  input  logic                          restart_req,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic                          seq_done,
  output logic                          fault,
  output logic [$clog2(NUM_STAGES)-1:0] fault_stage
);

  localparam int MAX_DT  = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
  localparam int CNT_MAX = (MAX_DT > DRAIN_DELAY) ? MAX_DT : DRAIN_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES);

  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_DELAY,
    S_WAIT_READY,
    S_RUN,
    S_FAULT,
    S_SHUTDOWN
  } state_t;

  state_t                  r_state,  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt,    w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx,    w_idx_nxt;
  logic [NUM_STAGES-1:0]   r_en,     w_en_nxt;
  logic                    r_done,   w_done_nxt;
  logic                    r_fault,  w_fault_nxt;
  logic [IDX_W-1:0]        r_fstage, w_fstage_nxt;

  logic [NUM_STAGES-1:0]   w_loss;
  logic [IDX_W-1:0]        w_loss_idx;
  logic [NUM_STAGES-1:0]   w_en_drop;
  logic                    w_go_shut;
  logic                    w_go_fault;
  logic [IDX_W-1:0]        w_fault_idx;

  function automatic logic [NUM_STAGES-1:0] clear_highest(input logic [NUM_STAGES-1:0] v);
    logic seen;
    clear_highest = v;
    seen          = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (v[i] && !seen) begin
        clear_highest[i] = 1'b0;
        seen             = 1'b1;
      end
    end
  endfunction

  assign w_loss    = r_en & ~stage_ready;
  assign w_en_drop = clear_highest(r_en);

  // Lowest-index enabled stage that lost ready.
  always_comb begin
    w_loss_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (w_loss[i]) w_loss_idx = IDX_W'(i);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_idx_nxt    = r_idx;
    w_en_nxt     = r_en;
    w_done_nxt   = r_done;
    w_fault_nxt  = r_fault;
    w_fstage_nxt = r_fstage;
    w_go_shut    = 1'b0;
    w_go_fault   = 1'b0;
    w_fault_idx  = r_idx;

    unique case (r_state)
      S_DELAY: begin
        if (restart_req) begin
          if (r_en != '0) begin
            w_go_shut = 1'b1;
          end else begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
          end
        end else if (r_cnt == DELAY_LAST) begin
          w_en_nxt[r_idx] = 1'b1;
          w_state_nxt     = S_WAIT_READY;
          w_cnt_nxt       = '0;
        end
      end

      S_WAIT_READY: begin
        if (restart_req) begin
          if (r_en != '0) begin
            w_go_shut = 1'b1;
          end else begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = S_DELAY;
          end
        end else if (stage_ready[r_idx]) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_DELAY;
          end
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_go_fault  = 1'b1;
          w_fault_idx = r_idx;
        end
      end

      S_RUN: begin
        w_cnt_nxt = '0;
        if (w_loss != '0) begin
          w_go_fault  = 1'b1;
          w_fault_idx = w_loss_idx;
        end else if (restart_req) begin
          w_go_shut = 1'b1;
        end
      end

      S_FAULT: begin
        w_cnt_nxt = '0;
        if (restart_req) begin
          w_fault_nxt  = 1'b0;
          w_fstage_nxt = '0;
          w_idx_nxt    = '0;
          w_state_nxt  = S_DELAY;
        end
      end

      S_SHUTDOWN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_en_nxt  = w_en_drop;
          w_cnt_nxt = '0;
          if (w_en_drop == '0) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DELAY;
          end
        end
      end

      default: begin
        w_state_nxt = S_DELAY;
        w_cnt_nxt   = '0;
      end
    endcase

    // Shutdown entry drops the top stage immediately; a lone stage 0 finishes the drain at once.
    if (w_go_shut) begin
      w_en_nxt   = w_en_drop;
      w_done_nxt = 1'b0;
      w_cnt_nxt  = '0;
      if (w_en_drop == '0) begin
        w_idx_nxt   = '0;
        w_state_nxt = S_DELAY;
      end else begin
        w_state_nxt = S_SHUTDOWN;
      end
    end

    if (w_go_fault) begin
      w_fault_nxt  = 1'b1;
      w_fstage_nxt = w_fault_idx;
      w_en_nxt     = '0;
      w_done_nxt   = 1'b0;
      w_cnt_nxt    = '0;
      w_state_nxt  = S_FAULT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk40) begin
    if (rst) begin
      r_state  <= S_DELAY;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_en     <= '0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
      r_fstage <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_en     <= w_en_nxt;
      r_done   <= w_done_nxt;
      r_fault  <= w_fault_nxt;
      r_fstage <= w_fstage_nxt;
    end
  end

  assign stage_en    = r_en;
  assign seq_done    = r_done;
  assign fault       = r_fault;
  assign fault_stage = r_fstage;

endmodule

// File: tb/tb_staged_enable_sequencer.sv
// Bench for staged_enable_sequencer: directed timing scenarios plus random traffic,
// all outputs compared every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_staged_enable_sequencer;

  localparam int N  = 4;
  localparam int D  = 62;
  localparam int T  = 1000;
  localparam int DD = 8;

  logic         clk40 = 1'b0;
  logic         rst;
  logic         restart_req;
  logic [N-1:0] stage_ready;
  logic [N-1:0] stage_en;
  logic         seq_done;
  logic         fault;
  logic [1:0]   fault_stage;

  int n_checks = 0;
  int n_fail   = 0;

  staged_enable_sequencer #(
    .NUM_STAGES (N),
    .DELAY      (D),
    .TIMEOUT    (T),
    .DRAIN_DELAY(DD)
  ) dut (
    .clk40      (clk40),
    .rst        (rst),
    .restart_req(restart_req),
    .stage_ready(stage_ready),
    .stage_en   (stage_en),
    .seq_done   (seq_done),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  always #12.5 clk40 = ~clk40;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {P_SEQ, P_RUN, P_FAULTED, P_DRAIN} phase_t;

  int           now     = 0;
  int           t_mark  = 0;
  int           t_rst   = 0;
  int           m_next  = 0;
  logic [N-1:0] m_en    = '0;
  bit           m_done  = 1'b0;
  bit           m_fault = 1'b0;
  int           m_fs    = 0;
  phase_t       m_phase = P_SEQ;
  bit           m_valid = 1'b0;

  function automatic logic [N-1:0] drop_top(input logic [N-1:0] v);
    drop_top = v;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        drop_top[i] = 1'b0;
        break;
      end
    end
  endfunction

  task automatic m_go_fault(input int s);
    m_fault = 1'b1;
    m_fs    = s;
    m_en    = '0;
    m_done  = 1'b0;
    m_phase = P_FAULTED;
  endtask

  task automatic m_start_drain();
    m_done = 1'b0;
    m_en   = drop_top(m_en);
    t_mark = now;
    if (m_en == '0) begin
      m_phase = P_SEQ;
      m_next  = 0;
    end else begin
      m_phase = P_DRAIN;
    end
  endtask

  always @(posedge clk40) begin
    logic [N-1:0] loss;
    now++;
    if (rst === 1'b1) begin
      m_en = '0; m_done = 1'b0; m_fault = 1'b0; m_fs = 0;
      m_phase = P_SEQ; m_next = 0; t_mark = now; t_rst = now; m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        P_SEQ: begin
          if (restart_req) begin
            if (m_en != '0) m_start_drain();
            else begin m_next = 0; t_mark = now; end
          end else if (!m_en[m_next]) begin
            if (now - t_mark == D) begin m_en[m_next] = 1'b1; t_mark = now; end
          end else if (stage_ready[m_next]) begin
            if (m_next == N - 1) begin m_phase = P_RUN; m_done = 1'b1; end
            else begin m_next++; t_mark = now; end
          end else if (now - t_mark == T) begin
            m_go_fault(m_next);
          end
        end
        P_RUN: begin
          loss = m_en & ~stage_ready;
          if (loss != '0) begin
            for (int i = 0; i < N; i++) if (loss[i]) begin m_go_fault(i); break; end
          end else if (restart_req) begin
            m_start_drain();
          end
        end
        P_FAULTED: begin
          if (restart_req) begin
            m_fault = 1'b0; m_fs = 0; m_phase = P_SEQ; m_next = 0; t_mark = now;
          end
        end
        P_DRAIN: begin
          if (now - t_mark == DD) begin
            m_en   = drop_top(m_en);
            t_mark = now;
            if (m_en == '0) begin m_phase = P_SEQ; m_next = 0; end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle comparison and event timestamps ----------------
  logic [N-1:0] prev_en    = '0;
  bit           prev_done  = 1'b0;
  bit           prev_fault = 1'b0;
  int           rise_t[N]  = '{-1, -1, -1, -1};
  int           done_t     = -1;
  int           fault_t    = -1;

  always @(negedge clk40) begin
    if (m_valid) begin
      check("stage_en",    32'(stage_en),    32'(m_en));
      check("seq_done",    32'(seq_done),    32'(m_done));
      check("fault",       32'(fault),       32'(m_fault));
      check("fault_stage", 32'(fault_stage), 32'(m_fs));
    end
    for (int k = 0; k < N; k++) if (stage_en[k] === 1'b1 && !prev_en[k]) rise_t[k] = now;
    if (seq_done === 1'b1 && !prev_done)  done_t  = now;
    if (fault === 1'b1 && !prev_fault)    fault_t = now;
    prev_en    = (stage_en === 'x) ? '0 : stage_en;
    prev_done  = (seq_done === 1'b1);
    prev_fault = (fault === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit rr, input logic [N-1:0] kill, input logic [N-1:0] junk);
    @(negedge clk40);
    rst         = r;
    restart_req = rr;
    stage_ready = (stage_en & ~kill) | (~stage_en & junk);
  endtask

  task automatic run(input int n, input logic [N-1:0] kill);
    repeat (n) cyc(1'b0, 1'b0, kill, '0);
  endtask

  int e_ref;
  logic [N-1:0] persist;
  logic [N-1:0] kill;

  initial begin
    rst = 1'b1; restart_req = 1'b0; stage_ready = '0;
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, '0);

    // Power-up with ready following enable.
    run(270, '0);
    check("pu_en0_time", 32'(rise_t[0] - t_rst), 32'd62);
    check("pu_en1_time", 32'(rise_t[1] - t_rst), 32'd125);
    check("pu_en2_time", 32'(rise_t[2] - t_rst), 32'd188);
    check("pu_en3_time", 32'(rise_t[3] - t_rst), 32'd251);
    check("pu_done_time", 32'(done_t - t_rst), 32'd252);
    check("pu_fault", 32'(fault), 32'd0);

    // Ready loss on stage 1 for one cycle while running.
    cyc(1'b0, 1'b0, 4'b0010, '0);
    @(posedge clk40); #1;
    check("loss_fault", 32'(fault), 32'd1);
    check("loss_stage", 32'(fault_stage), 32'd1);
    check("loss_en", 32'(stage_en), 32'd0);
    check("loss_done", 32'(seq_done), 32'd0);

    // Restart out of fault.
    cyc(1'b0, 1'b1, '0, '0);
    e_ref = now + 1;
    @(posedge clk40); #1;
    check("fclr_fault", 32'(fault), 32'd0);
    run(300, '0);
    check("fclr_en0_time", 32'(rise_t[0] - e_ref), 32'd62);
    check("fclr_done", 32'(seq_done), 32'd1);

    // Orderly restart from RUN.
    cyc(1'b0, 1'b1, '0, '0);
    e_ref = now + 1;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk40); #1;
      if (k == 0) begin
        check("drain_e0_en", 32'(stage_en), 32'b0111);
        check("drain_e0_done", 32'(seq_done), 32'd0);
      end
      if (k == 8)  check("drain_e8_en",  32'(stage_en), 32'b0011);
      if (k == 16) check("drain_e16_en", 32'(stage_en), 32'b0001);
      if (k == 24) check("drain_e24_en", 32'(stage_en), 32'b0000);
      cyc(1'b0, 1'b0, '0, '0);
    end
    run(300, '0);
    check("drain_en0_time", 32'(rise_t[0] - e_ref), 32'd86);
    check("drain_redone", 32'(seq_done), 32'd1);

    // Ready loss on stage 3 together with restart: fault wins.
    cyc(1'b0, 1'b1, 4'b1000, '0);
    @(posedge clk40); #1;
    check("prio_fault", 32'(fault), 32'd1);
    check("prio_stage", 32'(fault_stage), 32'd3);
    check("prio_en", 32'(stage_en), 32'd0);
    run(20, '0);
    check("prio_hold_en", 32'(stage_en), 32'd0);
    cyc(1'b0, 1'b1, '0, '0);
    run(300, '0);

    // Reset in the middle of a drain (stage_en = 0011).
    cyc(1'b0, 1'b1, '0, '0);
    e_ref = now + 1;
    run(8, '0);
    cyc(1'b1, 1'b0, '0, '0);
    @(posedge clk40); #1;
    check("mrst_en_pre", 32'(prev_en), 32'b0011);
    check("mrst_en", 32'(stage_en), 32'd0);
    check("mrst_done", 32'(seq_done), 32'd0);
    check("mrst_edge", 32'(t_rst - e_ref), 32'd9);
    run(100, '0);
    check("mrst_en0_time", 32'(rise_t[0] - t_rst), 32'd62);

    // Timeout on stage 2.
    cyc(1'b1, 1'b0, '0, '0);
    run(1250, 4'b0100);
    check("to_en2_time", 32'(rise_t[2] - t_rst), 32'd188);
    check("to_fault_time", 32'(fault_t - t_rst), 32'd1188);
    check("to_stage", 32'(fault_stage), 32'd2);
    check("to_en", 32'(stage_en), 32'd0);
    cyc(1'b0, 1'b1, '0, '0);
    e_ref = now + 1;
    run(100, '0);
    check("to_rst_en0_time", 32'(rise_t[0] - e_ref), 32'd62);

    // Randomised traffic; the model checks every cycle.
    persist = '0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 1999) == 0)
        persist = ($urandom_range(0, 3) == 0) ? N'(4'b0001 << $urandom_range(0, 3)) : '0;
      kill = persist;
      if ($urandom_range(0, 399) == 0) kill = kill | N'(4'b0001 << $urandom_range(0, 3));
      cyc(($urandom_range(0, 2999) == 0), ($urandom_range(0, 1499) == 0), kill, N'($urandom));
    end
    cyc(1'b0, 1'b0, '0, '0);
    @(negedge clk40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/staged_enable_sequencer.md
Name: staged_enable_sequencer

Overview:
- Sequences the board's subsystems out of power-up after the global reset.
- Asserts NUM_STAGES enables in a fixed order, stage 0 first. Each enable is separated by a settle delay and gated on the previous stage reporting ready.
- Monitors the running system and drops all enables on a timeout or a ready loss. On a restart request it shuts stages down in reverse order, then re-sequences.
- Sits directly after the global reset logic, on the 40 MHz domain.

Parameters:
- NUM_STAGES, 4, number of sequenced subsystems (2..8).
- DELAY, 62, clk40 cycles from one stage's acceptance to the next stage's enable (>=1).
- TIMEOUT, 1000, clk40 cycles a stage may take to report ready after its enable (>=1).
- DRAIN_DELAY, 8, clk40 cycles between successive enable drops during shutdown (>=1).

Ports:
- clk40  in  1  40 MHz system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- restart_req  in  1  single-cycle pulse requesting an orderly shutdown and re-sequence.
- stage_ready  in  NUM_STAGES  per-stage ready, level; bit i is meaningful only while stage_en[i]=1.
- stage_en  out  NUM_STAGES  per-stage enable, registered.
- seq_done  out  1  high while all stages are enabled and ready (RUN state).
- fault  out  1  sticky fault flag.
- fault_stage  out  clog2(NUM_STAGES)  index of the faulting stage; valid while fault=1.

Behaviour:
- Reset: one clock, synchronous, active-high (rst). Every edge with rst=1 forces:
  - stage_en=0, seq_done=0, fault=0, fault_stage=0;
  - idx=0, cnt=0, state=DELAY.
  - rst overrides all other inputs in every state.
- Counter: single cnt, width clog2(max(DELAY,TIMEOUT,DRAIN_DELAY)+1). Cleared on every state change. No wrap-around is reachable.
- Timing reference: "edge 0" is the last edge with rst=1, or the edge on which a stage is accepted or a restart/drain completes.
- States:
  - DELAY: cnt increments each edge. On the DELAY-th edge after entry: stage_en[idx]<=1, go to WAIT_READY. stage_ready is ignored in this state.
  - WAIT_READY:
    - stage_ready[idx]=1 sampled: stage accepted.
      - If idx=NUM_STAGES-1: go to RUN, seq_done<=1 on the same edge.
      - Otherwise: idx<=idx+1, go to DELAY.
    - If TIMEOUT edges elapse without ready: go to FAULT with fault_stage=idx.
    - Ready bits of not-yet-enabled stages are ignored.
  - RUN: if any enabled stage's ready is 0 (stage_en & ~stage_ready != 0): go to FAULT with fault_stage = lowest such index.
  - FAULT (entry edge): fault<=1, fault_stage latched, stage_en<=0 (all at once), seq_done<=0. The state holds until restart_req.
  - SHUTDOWN:
    - Entry edge: seq_done<=0 and the highest set stage_en bit clears.
    - Each further DRAIN_DELAY edges, the next lower set bit clears.
    - The edge that clears bit 0 is edge 0 for the restart: idx<=0, go to DELAY.
    - restart_req and stage_ready are ignored here.
- restart_req handling:
  - In RUN: go to SHUTDOWN.
  - In DELAY/WAIT_READY with stage_en!=0: go to SHUTDOWN, starting from the highest enabled stage.
  - In DELAY/WAIT_READY with stage_en=0: cnt<=0, idx<=0, stay in DELAY.
  - In FAULT: fault<=0, fault_stage<=0, idx<=0, go to DELAY.
- Simultaneous events:
  - In RUN, a ready-loss fault has priority over restart_req.
  - In WAIT_READY, ready on the timeout edge wins (stage accepted).
  - In WAIT_READY, restart_req has priority over ready and timeout.
- Outputs are registered, with no combinational path from any input.

Test Plan:
- Power-up, defaults, stage_ready tied to stage_en:
  - stage_en[0] rises at edge 62; stage_en[1..3] rise at edges 125, 188, 251;
  - seq_done=1 at edge 252; fault stays 0.
- Timeout, stage_ready[2] held 0:
  - stage_en[2] rises at edge 188; at edge 1188 fault=1, fault_stage=2, stage_en=0000, seq_done=0.
  - restart_req at a later edge R clears fault at R; stage_en[0] rises at R+62.
- Ready loss in RUN: drop stage_ready[1] for one cycle -> next edge fault=1, fault_stage=1, stage_en=0000, seq_done=0.
- Orderly restart, restart_req pulse in RUN at edge E:
  - stage_en=0111 and seq_done=0 at E; 0011 at E+8; 0001 at E+16; 0000 at E+24;
  - stage_en[0] rises at E+86.
- Fault priority: restart_req in RUN together with stage_ready[3]=0 -> fault=1, fault_stage=3, stage_en=0000; no shutdown sequence occurs.
- Mid-operation reset: rst=1 for 1 cycle during SHUTDOWN (stage_en=0011) -> all outputs 0 on that edge; stage_en[0] rises 62 edges later.
